// File: rtl/eth_report_tx.sv
// eth_report_tx: queues lookup/verdict reports and serialises each one as a
// fixed 60-byte Ethernet/IPv4/UDP notification frame on a 64-bit AXI-Stream.
// Optional build macro ARREST_ONLY_EN: when defined, only reports whose
// rpt_flag[2:1] == 2'b10 are queued; all other reports are ignored silently.
module eth_report_tx #(
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP     = 32'hC0A80164,
    parameter logic [31:0] DST_IP     = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT   = 16'd12346,
    parameter logic [15:0] DST_PORT   = 16'd12347,
    parameter int          FIFO_AW    = 3,
    parameter int          GAP_CYCLES = 4
) (
    input  logic        clk156,
    input  logic        eth_rst,
    input  logic [95:0] rpt_key,
    input  logic [3:0]  rpt_flag,
    input  logic        rpt_valid,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] tx_cnt,
    output logic [15:0] drop_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_CSUM = 2'd1,
        TX_SEND = 2'd2,
        TX_GAP  = 2'd3
    } state_t;

    // IPv4 header checksum: ones-complement sum, carries folded twice, inverted.
    function automatic logic [15:0] ip_csum(input logic [15:0] seq);
        logic [19:0] sum;
        logic [16:0] fold1;
        logic [15:0] fold2;
        sum = 20'h04500 + 20'h0002C + {4'h0, seq} + 20'h04000 + 20'h04011
            + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
            + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
        fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        return ~fold2;
    endfunction

    // Whole frame, wire byte n placed at bits [8n+7:8n]; bytes 60-63 are padding.
    function automatic logic [511:0] build_frame(input logic [95:0] key, input logic [3:0] flag,
                                                 input logic [15:0] seq, input logic [15:0] csum);
        logic [511:0] be;
        logic [511:0] le;
        be = {DST_MAC, SRC_MAC, 16'h0800,
              16'h4500, 16'h002C, seq, 16'h4000, 8'h40, 8'h11, csum, SRC_IP, DST_IP,
              SRC_PORT, DST_PORT, 16'h0018, 16'h0000,
              key, 4'h0, flag, 8'h00, seq, 16'h0000, 32'h0000_0000};
        le = '0;
        for (int i = 0; i < 64; i++) begin
            le[8*i +: 8] = be[511-8*i -: 8];
        end
        return le;
    endfunction

    logic [99:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    state_t             r_state;
    logic [99:0]        r_hold;
    logic [15:0]        r_seq;
    logic [15:0]        r_csum;
    logic [2:0]         r_beat;
    logic [GW-1:0]      r_gap;

    logic               w_accept;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [15:0]        w_csum;
    logic [511:0]       w_frame;
    logic [2:0]         w_next_beat;
    logic [63:0]        w_next_data;

`ifdef ARREST_ONLY_EN
    assign w_accept = (rpt_flag[2:1] == 2'b10);
`else
    assign w_accept = 1'b1;
`endif

    // Count reaches DEPTH exactly when its MSB is set.
    assign w_empty     = (r_count == '0);
    assign w_full      = r_count[FIFO_AW];
    assign w_pop       = (r_state == TX_IDLE) && !w_empty;
    assign w_push      = rpt_valid && w_accept && (!w_full || w_pop);
    assign w_drop      = rpt_valid && w_accept && w_full && !w_pop;
    assign w_csum      = ip_csum(r_seq);
    // Beat 0 carries no checksum bytes, so it may be built before r_csum loads.
    assign w_frame     = build_frame(r_hold[99:4], r_hold[3:0], r_seq, r_csum);
    assign w_next_beat = r_beat + 3'd1;
    assign w_next_data = w_frame[{w_next_beat, 6'd0} +: 64];
    assign m_axis_tuser = 1'b0;

    // Report storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk156) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {rpt_key, rpt_flag};
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            drop_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Frame sequencer with registered AXI-Stream outputs and frame/seq counters.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_state       <= TX_IDLE;
            r_hold        <= '0;
            r_seq         <= 16'd0;
            r_csum        <= 16'd0;
            r_beat        <= 3'd0;
            r_gap         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 64'd0;
            m_axis_tkeep  <= 8'h00;
            m_axis_tlast  <= 1'b0;
            tx_cnt        <= 16'd0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (!w_empty) begin
                        r_hold  <= r_mem[r_rd_ptr];
                        r_state <= TX_CSUM;
                    end
                end
                TX_CSUM: begin
                    r_csum        <= w_csum;
                    r_beat        <= 3'd0;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= w_frame[63:0];
                    m_axis_tkeep  <= 8'hFF;
                    m_axis_tlast  <= 1'b0;
                    r_state       <= TX_SEND;
                end
                TX_SEND: begin
                    if (m_axis_tready) begin
                        if (r_beat == 3'd7) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= 64'd0;
                            m_axis_tkeep  <= 8'h00;
                            m_axis_tlast  <= 1'b0;
                            tx_cnt        <= tx_cnt + 16'd1;
                            r_seq         <= r_seq + 16'd1;
                            r_gap         <= '0;
                            r_state       <= TX_GAP;
                        end else begin
                            r_beat        <= w_next_beat;
                            m_axis_tdata  <= w_next_data;
                            m_axis_tkeep  <= (w_next_beat == 3'd7) ? 8'h0F : 8'hFF;
                            m_axis_tlast  <= (w_next_beat == 3'd7);
                        end
                    end
                end
                TX_GAP: begin
                    if (r_gap == GW'(GAP_CYCLES - 1)) begin
                        r_state <= TX_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
